// File: rtl/pc_write_controller_if.sv
// pc_write_controller_if: pipeline-facing signals of the PC write controller
interface pc_write_controller_if #(parameter int CNT_W = 16);
    logic [31:0]      PCResult;
    logic             IMemReady;
    logic             LoadUseHazard;
    logic             MemBranchTaken;
    logic [31:0]      MemBranchTarget;
    logic             MemJump;
    logic [31:0]      MemJumpTarget;
    logic             Halt;
    logic [31:0]      Address;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_MEM_Flush;
    logic             Halted;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushEvents;
    modport master (
        input  PCResult, IMemReady, LoadUseHazard, MemBranchTaken, MemBranchTarget,
               MemJump, MemJumpTarget, Halt,
        output Address, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
               Halted, StallCycles, FlushEvents
    );
    modport slave (
        output PCResult, IMemReady, LoadUseHazard, MemBranchTaken, MemBranchTarget,
               MemJump, MemJumpTarget, Halt,
        input  Address, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
               Halted, StallCycles, FlushEvents
    );
endinterface

// File: rtl/pc_write_controller.sv
// pc_write_controller: next-PC selection, fetch stall/flush control and event counters
module pc_write_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 16
) (
    input logic                    Clk,
    input logic                    Reset,
    pc_write_controller_if.master  bus
);
    typedef enum logic [1:0] {RUN, PEND, HALTED} state_t;
    state_t           state, state_nx;
    logic [31:0]      pend_tgt, address, target;
    logic             redirect, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
    logic             latch_tgt, flush_evt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    assign redirect = bus.MemJump | bus.MemBranchTaken;
    assign target   = bus.MemJump ? bus.MemJumpTarget : bus.MemBranchTarget;
    // Next-state and fetch controls; a redirect always outranks halt and stalls
    always_comb begin
        state_nx     = state;
        address      = bus.PCResult;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        latch_tgt    = 1'b0;
        flush_evt    = 1'b0;
        if (Reset) begin
            state_nx     = RUN;
            address      = RESET_VECTOR;
            pc_write     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (state)
                RUN, PEND: begin
                    if (redirect) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        flush_evt    = 1'b1;
                        pc_write     = bus.IMemReady;
                        address      = bus.IMemReady ? target : bus.PCResult;
                        latch_tgt    = !bus.IMemReady;
                        state_nx     = bus.IMemReady ? RUN : PEND;
                    end else if (state == PEND) begin
                        pc_write    = bus.IMemReady;
                        if_id_flush = bus.IMemReady;
                        address     = bus.IMemReady ? pend_tgt : bus.PCResult;
                        state_nx    = bus.IMemReady ? RUN : PEND;
                    end else if (bus.Halt) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_nx    = HALTED;
                    end else if (bus.IMemReady && bus.LoadUseHazard) begin
                        id_ex_flush = 1'b1;
                    end else if (bus.IMemReady) begin
                        address     = bus.PCResult + 32'd4;
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
                default: if_id_flush = 1'b1;
            endcase
        end
    end
    // State register and the redirect target held across an instruction-memory wait
    always_ff @(posedge Clk) begin
        state    <= state_nx;
        pend_tgt <= Reset ? 32'h0 : latch_tgt ? target : pend_tgt;
    end
    // Saturating event counters; halted cycles are not counted as stalls
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state != HALTED && !pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush_evt && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
    assign bus.Address      = address;
    assign bus.PCWrite      = pc_write;
    assign bus.IF_ID_Write  = if_id_write;
    assign bus.IF_ID_Flush  = if_id_flush;
    assign bus.ID_EX_Flush  = id_ex_flush;
    assign bus.EX_MEM_Flush = ex_mem_flush;
    assign bus.Halted       = state == HALTED;
    assign bus.StallCycles  = stall_cnt;
    assign bus.FlushEvents  = flush_cnt;
endmodule

// File: tb/tb_pc_write_controller.sv
// tb_pc_write_controller: directed vector table plus halt and counter-saturation sequences
module tb_pc_write_controller;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    pc_write_controller_if #(.CNT_W(16)) bus ();
    pc_write_controller #(.RESET_VECTOR(32'h0000_0000), .CNT_W(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.master)
    );
    always #5 Clk = ~Clk;
    // in_f = {Reset, IMemReady, LoadUseHazard, MemBranchTaken, MemJump, Halt}
    // out_f = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Halted}
    typedef struct {
        logic [5:0]  in_f;
        logic [31:0] pc;
        logic [31:0] bt;
        logic [31:0] jt;
        logic [31:0] addr;
        logic [5:0]  out_f;
        logic [15:0] s;
        logic [15:0] f;
    } vec_t;
    vec_t vq[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask
    task automatic drive(input logic [5:0] f, input logic [31:0] pc, input logic [31:0] bt,
                         input logic [31:0] jt);
        {Reset, bus.IMemReady, bus.LoadUseHazard, bus.MemBranchTaken, bus.MemJump, bus.Halt} = f;
        bus.PCResult        = pc;
        bus.MemBranchTarget = bt;
        bus.MemJumpTarget   = jt;
    endtask
    function automatic logic [5:0] outs();
        return {bus.PCWrite, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Flush,
                bus.EX_MEM_Flush, bus.Halted};
    endfunction
    initial begin
        vq.push_back('{6'b110000, 32'h0,   32'h0,   32'h0,   32'h0,   6'b101110, 16'd0, 16'd0});
        vq.push_back('{6'b010000, 32'h0,   32'h0,   32'h0,   32'h4,   6'b110000, 16'd0, 16'd0});
        vq.push_back('{6'b010000, 32'h4,   32'h0,   32'h0,   32'h8,   6'b110000, 16'd0, 16'd0});
        vq.push_back('{6'b010000, 32'h8,   32'h0,   32'h0,   32'hC,   6'b110000, 16'd0, 16'd0});
        vq.push_back('{6'b010000, 32'hC,   32'h0,   32'h0,   32'h10,  6'b110000, 16'd0, 16'd0});
        vq.push_back('{6'b011000, 32'h10,  32'h0,   32'h0,   32'h10,  6'b000100, 16'd0, 16'd0});
        vq.push_back('{6'b010000, 32'h10,  32'h0,   32'h0,   32'h14,  6'b110000, 16'd1, 16'd0});
        vq.push_back('{6'b011100, 32'h14,  32'h40,  32'h0,   32'h40,  6'b101110, 16'd1, 16'd0});
        vq.push_back('{6'b010000, 32'h40,  32'h0,   32'h0,   32'h44,  6'b110000, 16'd1, 16'd1});
        vq.push_back('{6'b000110, 32'h44,  32'h40,  32'h80,  32'h44,  6'b001110, 16'd1, 16'd1});
        vq.push_back('{6'b000000, 32'h44,  32'h0,   32'h0,   32'h44,  6'b000000, 16'd2, 16'd2});
        vq.push_back('{6'b000000, 32'h44,  32'h0,   32'h0,   32'h44,  6'b000000, 16'd3, 16'd2});
        vq.push_back('{6'b010000, 32'h44,  32'h0,   32'h0,   32'h80,  6'b101000, 16'd4, 16'd2});
        vq.push_back('{6'b010000, 32'h80,  32'h0,   32'h0,   32'h84,  6'b110000, 16'd4, 16'd2});
        vq.push_back('{6'b010001, 32'h24,  32'h0,   32'h0,   32'h24,  6'b001100, 16'd4, 16'd2});
        vq.push_back('{6'b010100, 32'h24,  32'h40,  32'h0,   32'h24,  6'b001001, 16'd5, 16'd2});
        vq.push_back('{6'b001011, 32'h24,  32'h0,   32'h80,  32'h24,  6'b001001, 16'd5, 16'd2});
        vq.push_back('{6'b100000, 32'h24,  32'h0,   32'h0,   32'h0,   6'b101111, 16'd5, 16'd2});
        vq.push_back('{6'b010000, 32'h0,   32'h0,   32'h0,   32'h4,   6'b110000, 16'd0, 16'd0});
        vq.push_back('{6'b000100, 32'h4,   32'h100, 32'h0,   32'h4,   6'b001110, 16'd0, 16'd0});
        vq.push_back('{6'b000010, 32'h4,   32'h0,   32'h200, 32'h4,   6'b001110, 16'd1, 16'd1});
        vq.push_back('{6'b010000, 32'h4,   32'h0,   32'h0,   32'h200, 6'b101000, 16'd2, 16'd2});
        vq.push_back('{6'b000100, 32'h200, 32'h300, 32'h0,   32'h200, 6'b001110, 16'd2, 16'd2});
        vq.push_back('{6'b010100, 32'h200, 32'h500, 32'h0,   32'h500, 6'b101110, 16'd3, 16'd3});
        vq.push_back('{6'b000100, 32'h500, 32'h600, 32'h0,   32'h500, 6'b001110, 16'd3, 16'd4});
        vq.push_back('{6'b000001, 32'h500, 32'h0,   32'h0,   32'h500, 6'b000000, 16'd4, 16'd5});
        vq.push_back('{6'b100000, 32'h500, 32'h0,   32'h0,   32'h0,   6'b101110, 16'd5, 16'd5});
        vq.push_back('{6'b010000, 32'h0,   32'h0,   32'h0,   32'h4,   6'b110000, 16'd0, 16'd0});
        vq.push_back('{6'b010000, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 6'b110000, 16'd0, 16'd0});
        drive(6'b110000, 32'h0, 32'h0, 32'h0);
        @(posedge Clk);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge Clk);
            drive(vq[i].in_f, vq[i].pc, vq[i].bt, vq[i].jt);
            #1;
            chk($sformatf("v%0d Address", i), bus.Address, vq[i].addr);
            chk($sformatf("v%0d ctl", i), {26'd0, outs()}, {26'd0, vq[i].out_f});
            chk($sformatf("v%0d StallCycles", i), {16'd0, bus.StallCycles}, {16'd0, vq[i].s});
            chk($sformatf("v%0d FlushEvents", i), {16'd0, bus.FlushEvents}, {16'd0, vq[i].f});
        end
        @(negedge Clk);
        drive(6'b010001, 32'h24, 32'h0, 32'h0);
        #1;
        chk("halt entry PCWrite", {31'd0, bus.PCWrite}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            drive(i[0] ? 6'b010100 : 6'b000010, 32'h24, 32'h40, 32'h80);
            #1;
            chk($sformatf("halted%0d PCWrite", i), {31'd0, bus.PCWrite}, 32'd0);
            chk($sformatf("halted%0d Halted", i), {31'd0, bus.Halted}, 32'd1);
            chk($sformatf("halted%0d StallCycles", i), {16'd0, bus.StallCycles}, 32'd1);
        end
        @(negedge Clk);
        drive(6'b100000, 32'h24, 32'h0, 32'h0);
        #1;
        chk("halt reset Address", bus.Address, 32'h0);
        @(negedge Clk);
        drive(6'b000000, 32'h30, 32'h0, 32'h0);
        for (int i = 0; i < 65535; i++) @(posedge Clk);
        @(negedge Clk);
        #1;
        chk("stall saturated", {16'd0, bus.StallCycles}, 32'h0000_FFFF);
        for (int i = 0; i < 5; i++) @(posedge Clk);
        @(negedge Clk);
        #1;
        chk("stall held", {16'd0, bus.StallCycles}, 32'h0000_FFFF);
        chk("stall FlushEvents", {16'd0, bus.FlushEvents}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
